// File: rtl/clock_time_keeper.sv
// clock_time_keeper: BCD time-of-day counter with button set mode and day-rollover pulse.
// Define TWELVE_HOUR_EN for 12-hour counting with the o_pm flag.
module clock_time_keeper #(
    parameter int INIT_HOUR = 0,
    parameter int INIT_MIN  = 0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_mode,
    input  logic       i_up,
    output logic [7:0] o_hour_bcd,
    output logic [7:0] o_min_bcd,
    output logic [7:0] o_sec_bcd,
    output logic [1:0] o_mode,
    output logic       o_day_pulse
`ifdef TWELVE_HOUR_EN
    ,
    output logic       o_pm
`endif
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10} mode_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        bcd_inc = (v == top) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

`ifdef TWELVE_HOUR_EN
    localparam int   H_INIT  = (INIT_HOUR == 0) ? 12 : (INIT_HOUR > 12) ? INIT_HOUR - 12 : INIT_HOUR;
    localparam logic PM_INIT = INIT_HOUR >= 12;
`else
    localparam int   H_INIT  = INIT_HOUR;
`endif
    localparam logic [7:0] HOUR_RST = {4'(H_INIT / 10), 4'(H_INIT % 10)};
    localparam logic [7:0] MIN_RST  = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10)};

    mode_t      state;
    logic [7:0] hour_next;
    logic       day_roll;
    logic       sec_wrap;
    logic       min_wrap;

    assign o_mode   = state;
    assign sec_wrap = o_sec_bcd == 8'h59;
    assign min_wrap = o_min_bcd == 8'h59;
`ifdef TWELVE_HOUR_EN
    logic pm_flip;
    // 12-hour sequence is 12, 01..11; the flag flips on 11 -> 12
    assign hour_next = (o_hour_bcd == 8'h12) ? 8'h01 : bcd_inc(o_hour_bcd, 8'h12);
    assign pm_flip   = o_hour_bcd == 8'h11;
    assign day_roll  = o_pm && pm_flip;
`else
    assign hour_next = bcd_inc(o_hour_bcd, 8'h23);
    assign day_roll  = o_hour_bcd == 8'h23;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= RUN;
            o_hour_bcd  <= HOUR_RST;
            o_min_bcd   <= MIN_RST;
            o_sec_bcd   <= 8'h00;
            o_day_pulse <= 1'b0;
`ifdef TWELVE_HOUR_EN
            o_pm        <= PM_INIT;
`endif
        end else begin
            o_day_pulse <= 1'b0;
            case (state)
                RUN: begin
                    if (i_tick) begin
                        o_sec_bcd <= bcd_inc(o_sec_bcd, 8'h59);
                        if (sec_wrap) begin
                            o_min_bcd <= bcd_inc(o_min_bcd, 8'h59);
                            if (min_wrap) begin
                                o_hour_bcd  <= hour_next;
                                o_day_pulse <= day_roll;
`ifdef TWELVE_HOUR_EN
                                o_pm        <= o_pm ^ pm_flip;
`endif
                            end
                        end
                    end
                    // entering set mode overrides the tick's seconds update
                    if (i_mode) begin
                        state     <= SET_HOUR;
                        o_sec_bcd <= 8'h00;
                    end
                end
                SET_HOUR: begin
                    if (i_mode) begin
                        state <= SET_MIN;
                    end else if (i_up) begin
                        o_hour_bcd <= hour_next;
`ifdef TWELVE_HOUR_EN
                        o_pm       <= o_pm ^ pm_flip;
`endif
                    end
                end
                SET_MIN: begin
                    if (i_mode) state <= RUN;
                    else if (i_up) o_min_bcd <= bcd_inc(o_min_bcd, 8'h59);
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_time_keeper.sv
// tb_clock_time_keeper: randomized check of clock_time_keeper against a seconds-of-day model.
module tb_clock_time_keeper;
    localparam int INIT_HOUR = 23;
    localparam int INIT_MIN  = 59;

    logic       i_clk = 1'b0;
    logic       i_reset, i_tick, i_mode, i_up;
    logic [7:0] o_hour_bcd, o_min_bcd, o_sec_bcd;
    logic [1:0] o_mode;
    logic       o_day_pulse;
`ifdef TWELVE_HOUR_EN
    logic       o_pm;
`endif

    int vectors = 0;
    int errors  = 0;
    int t;
    int md;
    bit dp;

    clock_time_keeper #(.INIT_HOUR(INIT_HOUR), .INIT_MIN(INIT_MIN)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_mode     (i_mode),
        .i_up       (i_up),
        .o_hour_bcd (o_hour_bcd),
        .o_min_bcd  (o_min_bcd),
        .o_sec_bcd  (o_sec_bcd),
        .o_mode     (o_mode),
        .o_day_pulse(o_day_pulse)
`ifdef TWELVE_HOUR_EN
        ,
        .o_pm       (o_pm)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0d mode=%0d) at %0t", tag, got, exp, t, md, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic int disp_hour();
        int h = t / 3600;
`ifdef TWELVE_HOUR_EN
        h = (h % 12 == 0) ? 12 : h % 12;
`endif
        return h;
    endfunction

    task automatic model_reset();
        t  = INIT_HOUR * 3600 + INIT_MIN * 60;
        md = 0;
        dp = 0;
    endtask

    // Time is plain seconds-of-day; 12-hour display is derived from it
    task automatic model_step(input bit tk, input bit m, input bit u);
        int h = t / 3600;
        int mi = (t / 60) % 60;
        int s = t % 60;
        dp = 0;
        case (md)
            0: begin
                if (tk) begin
                    t++;
                    if (t == 86400) begin
                        t  = 0;
                        dp = 1;
                    end
                end
                if (m) begin
                    md = 1;
                    t  = t - t % 60;
                end
            end
            1: if (m) md = 2; else if (u) t = ((h + 1) % 24) * 3600 + mi * 60 + s;
            default: if (m) md = 0; else if (u) t = h * 3600 + ((mi + 1) % 60) * 60 + s;
        endcase
    endtask

    task automatic compare();
        check("hour", o_hour_bcd, bcd(disp_hour()));
        check("min", o_min_bcd, bcd((t / 60) % 60));
        check("sec", o_sec_bcd, bcd(t % 60));
        check("mode", {6'b0, o_mode}, 8'(md));
        check("day_pulse", {7'b0, o_day_pulse}, {7'b0, dp});
`ifdef TWELVE_HOUR_EN
        check("pm", {7'b0, o_pm}, {7'b0, t >= 43200});
`endif
    endtask

    task automatic cycle(input bit tk, input bit m, input bit u);
        i_tick = tk;
        i_mode = m;
        i_up   = u;
        @(posedge i_clk);
        model_step(tk, m, u);
        @(negedge i_clk);
        i_tick = 1'b0;
        i_mode = 1'b0;
        i_up   = 1'b0;
        compare();
    endtask

    initial begin
        i_reset = 1'b1;
        i_tick  = 1'b0;
        i_mode  = 1'b0;
        i_up    = 1'b0;
        #2 i_reset = 1'b0;
        #1 model_reset();
        compare();
        @(negedge i_clk);
        compare();
        i_reset = 1'b1;
        repeat (60) cycle(1, 0, 0);
        cycle(0, 0, 0);
        // set 10:20 via buttons, leave set mode with a coincident tick
        cycle(0, 1, 0);
        repeat (10) cycle(0, 0, 1);
        cycle(0, 1, 0);
        repeat (20) cycle(0, 0, 1);
        cycle(1, 1, 0);
        repeat (35) cycle(1, 0, 1);
        cycle(0, 1, 0);
        repeat (15) cycle(0, 0, 1);
        repeat (3) cycle(1, 0, 0);
        cycle(0, 1, 1);
        repeat (65) cycle(1, 0, 1);
        cycle(0, 1, 0);
        repeat (5) cycle(1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #2 i_reset = 1'b0;
                #1 model_reset();
                compare();
                @(negedge i_clk);
                i_reset = 1'b1;
                compare();
                cycle(1, 0, 0);
            end
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Time-of-day counter for the digital clock, directly downstream of the clock divider. Consumes the divider's one-cycle 1 Hz tick and keeps hours, minutes and seconds as BCD. Provides a button-driven set mode for hours and minutes, and a day-rollover pulse. Outputs feed the 7-segment display driver.

## Interface
- INIT_HOUR, 0 — reset hour in 24-h form, 0..23
- INIT_MIN, 0 — reset minute, 0..59
- i_clk  input  1  system clock; same clock as the divider
- i_reset  input  1  asynchronous, active-low reset
- i_tick  input  1  one-cycle 1 Hz pulse from the divider
- i_mode  input  1  one-cycle pulse, debounced mode button
- i_up  input  1  one-cycle pulse, debounced increment button
- o_hour_bcd  output  8  hours; [7:4] tens, [3:0] ones
- o_min_bcd  output  8  minutes, BCD
- o_sec_bcd  output  8  seconds, BCD
- o_mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN
- o_day_pulse  output  1  one-cycle pulse on day rollover
- o_pm  output  1  PM flag; only present with TWELVE_HOUR_EN

## Operation
- All state and outputs are registered; there is no combinational input-to-output path.
- **Reset:**
  - o_hour_bcd = INIT_HOUR in BCD, o_min_bcd = INIT_MIN in BCD, o_sec_bcd = 8'h00.
  - o_mode = 00, o_day_pulse = 0.
- **FSM transitions:**
  - RUN -i_mode-> SET_HOUR -i_mode-> SET_MIN -i_mode-> RUN.
  - 2'b11 is unreachable; if entered, the FSM goes to RUN on the next clock.
- **RUN:**
  - i_tick increments seconds.
  - Seconds 59→00 carries into minutes; minutes 59→00 carries into hours.
  - Hours 23:59:59 → 00:00:00 asserts o_day_pulse for one cycle.
  - i_up is ignored.
- **SET_HOUR / SET_MIN:**
  - i_tick is ignored.
  - Seconds are forced to 00 on the clock edge that enters SET_HOUR and held there.
  - i_up increments the selected field only.
  - Hour wraps 23→00 and minute wraps 59→00, with no carry and no o_day_pulse.
- **Priority within one cycle:**
  - i_mode wins; a simultaneous i_up is dropped.
  - i_tick is evaluated against the current state, before any transition.
  - i_tick in the same cycle as the SET_MIN→RUN i_mode is dropped.
- BCD ones digits wrap 9→0 with a carry into tens; no digit ever holds a value above 9.

## Timing
- Latency: the field update is visible on the outputs one cycle after i_tick or i_up is sampled high.
- o_day_pulse is high in the same cycle the outputs first show 00:00:00.
- o_mode changes one cycle after i_mode is sampled.
- Asserting i_reset mid-operation forces reset values asynchronously. The first tick after deassertion counts normally.
- Back-to-back i_tick pulses on consecutive cycles are each counted.

## Configuration
- TWELVE_HOUR_EN defined:
  - Hours count 12, 01..11, 12.
  - o_pm toggles on the 11→12 hour transition, in both RUN and SET_HOUR.
  - o_day_pulse fires on 11:59:59 PM → 12:00:00 AM.
  - Reset maps INIT_HOUR: 0→12 AM, 1..11 AM, 12→12 PM, 13..23 → 01..11 PM.
- TWELVE_HOUR_EN undefined: 24-hour counting and the o_pm port is absent.

## Test plan
- Reset with INIT_HOUR=0, INIT_MIN=0, then 61 ticks → outputs 00:01:01, o_mode=00, o_day_pulse never high.
- Reset with INIT_HOUR=23, INIT_MIN=59, then 59 ticks → 23:59:59; tick 60 → 00:00:00 with a single-cycle o_day_pulse.
- Mode pulse in RUN at 10:20:35 → o_mode=01 and seconds=00. Then 15 i_up pulses → hour 01, no day pulse. Then 3 ticks → time unchanged. Then two mode pulses → o_mode=00, RUN resumes from 01:20:00.
- i_mode and i_up in the same cycle in SET_HOUR → o_mode=10, hour unchanged. i_tick coincident with the SET_MIN→RUN mode pulse → seconds stay 00.
- i_reset asserted low mid-count at 05:33:17 → outputs return to INIT values immediately (asynchronously), before the next clock edge.
- TWELVE_HOUR_EN, INIT_HOUR=11, INIT_MIN=59, then 60 ticks → 12:00:00 with o_pm=1 and no o_day_pulse. A further 12 h of ticks → 12:00:00 with o_pm=0 and o_day_pulse asserted.
